// File: rtl/if_fetch_queue_pkg.sv
// Shared definitions for the IF->ID fetch queue: memory map constants and
// the {pc, instr} entry layout held in each queue slot.
package if_fetch_queue_pkg;

    localparam logic [31:0] TEXT_STARTADDR = 32'h0000_3000;
    localparam logic [31:0] INSTR_NOP      = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fq_entry_t;

    function automatic fq_entry_t fq_pack(input logic [31:0] pc, input logic [31:0] instr);
        fq_entry_t e;
        e.pc    = pc;
        e.instr = instr;
        return e;
    endfunction

endpackage

// File: rtl/if_fetch_queue_fq_storage.sv
// DEPTH x 64 register array for the fetch queue: one synchronous write port,
// one asynchronous read port. Contents carry no reset.
module if_fetch_queue_fq_storage
    import if_fetch_queue_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_we,
    input  logic [PTR_W-1:0] i_waddr,
    input  fq_entry_t        i_wdata,
    input  logic [PTR_W-1:0] i_raddr,
    output fq_entry_t        o_rdata
);

    fq_entry_t r_mem [DEPTH];

    // Write port: an entry changes only when the queue pushes into it.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/if_fetch_queue.sv
// Fetch queue between IF and ID: buffers (PC, instruction) pairs in order,
// stalls the PC when full and drops everything on a redirect flush.
module if_fetch_queue
    import if_fetch_queue_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [31:0]      in_pc,
    input  logic [31:0]      in_instr,
    output logic             pc_en,
    input  logic             flush,
    output logic             out_valid,
    output logic [31:0]      out_pc,
    output logic [31:0]      out_instr,
    input  logic             out_ready,
    output logic [PTR_W:0]   count
);

    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic      w_full;
    logic      w_not_empty;
    logic      w_push;
    logic      w_pop;
    fq_entry_t w_head;

    // Full/empty come from the registered count, so a pop at full cannot
    // make room for a push in the same cycle.
    assign w_full      = (r_count == FULL_CNT);
    assign w_not_empty = (r_count != {CNT_W{1'b0}});
    assign w_push      = in_valid & ~w_full & ~flush;
    assign w_pop       = w_not_empty & out_ready & ~flush;

    assign pc_en     = ~w_full | flush;
    assign out_valid = w_not_empty;
    assign out_pc    = w_not_empty ? w_head.pc    : 32'h0000_0000;
    assign out_instr = w_not_empty ? w_head.instr : INSTR_NOP;
    assign count     = r_count;

    if_fetch_queue_fq_storage #(.DEPTH(DEPTH)) u_storage (
        .i_clk   (clk),
        .i_we    (w_push),
        .i_waddr (r_wr_ptr),
        .i_wdata (fq_pack(in_pc, in_instr)),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_head)
    );

    // Pointer and occupancy state; reset dominates flush, flush dominates push/pop.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= {PTR_W{1'b0}};
            r_rd_ptr <= {PTR_W{1'b0}};
            r_count  <= {CNT_W{1'b0}};
        end else if (flush) begin
            r_wr_ptr <= {PTR_W{1'b0}};
            r_rd_ptr <= {PTR_W{1'b0}};
            r_count  <= {CNT_W{1'b0}};
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end else begin
                r_wr_ptr <= r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end else begin
                r_rd_ptr <= r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: doc/if_fetch_queue.md
Name: if_fetch_queue

Overview:
Reader side of the program-counter fetch interface. It captures each (PC, instruction) pair produced by IF into a small circular queue and presents the pairs in order to ID through a valid/ready handshake. It generates the PC write-enable, which deasserts when the queue is full so that the PC holds. A redirect flush (branch, jump or exception) discards all queued entries in one cycle.

Parameters:
DEPTH, 4, number of queue entries; must be a power of 2 and at least 2
PTR_W, $clog2(DEPTH), read/write pointer width (derived; do not override)

Ports:
clk  in  1  clock; all state updates on posedge
reset  in  1  synchronous, active-high reset
in_valid  in  1  IF presents a fetched instruction this cycle
in_pc  in  32  PC of the fetched instruction
in_instr  in  32  instruction word read at in_pc
pc_en  out  1  write-enable to the PC register; 0 stalls the PC
flush  in  1  redirect: discard all entries; the PC takes the new target this cycle
out_valid  out  1  head entry is available to ID
out_pc  out  32  PC of the head entry
out_instr  out  32  instruction of the head entry
out_ready  in  1  ID consumes the head entry this cycle
count  out  PTR_W+1  number of occupied entries (0..DEPTH)

Behaviour:
- Storage: DEPTH entries of {pc, instr}; wr_ptr and rd_ptr are PTR_W bits wide; count is held as a register.
- Reset (sync, clk edge with reset=1): wr_ptr=0, rd_ptr=0, count=0. Entry contents are don't-care.
  - Resulting outputs: out_valid=0, out_pc=0, out_instr=0, pc_en=1.
  - reset overrides flush, push and pop in the same cycle.
- Output values:
  - out_valid = (count != 0).
  - out_pc and out_instr come combinationally from the entry at rd_ptr when out_valid=1; both are forced to 32'h0 when the queue is empty.
  - There is no fall-through: an entry pushed in cycle N first appears at the outputs in cycle N+1. Latency is 1 cycle.
- pc_en = (count != DEPTH) | flush.
  - When full, the PC holds.
  - On flush, the PC always loads the redirect target.
- push = in_valid & (count != DEPTH) & ~flush.
  - On push, write the entry at wr_ptr, then wr_ptr+1 with natural wrap modulo DEPTH.
- pop = out_valid & out_ready & ~flush.
  - On pop, rd_ptr+1 with wrap.
- Count update:
  - push only: count+1.
  - pop only: count-1.
  - push and pop in the same cycle: count unchanged. This is legal at any 0<count<DEPTH.
- Full (count=DEPTH):
  - in_valid is ignored and no entry is overwritten.
  - A pop in the same cycle frees one slot, but the push is still refused that cycle because pc_en is decided from the registered count.
- Empty (count=0):
  - out_ready is ignored and pop does not occur.
  - A push in the same cycle yields count=1 at the next edge.
- Flush (flush=1, reset=0): next edge gives wr_ptr=rd_ptr=0 and count=0.
  - The same-cycle push is dropped; that instruction belongs to the wrong path.
  - A same-cycle pop is not performed; ID must treat its own stage as flushed too.
- Flush held on consecutive cycles: the queue stays empty and pc_en stays 1.
- Entry contents are never modified except by a push.

Decomposition:
- Shared package/header: TEXT_STARTADDR (existing memory config, used by PC) and INSTR_NOP = 32'h0.
- One natural sub-module: fq_storage. It is a DEPTH x 64 register array with a synchronous write port (we, waddr, wdata) and an asynchronous read port (raddr, rdata). All pointer and count logic stays in if_fetch_queue.

Test Plan:
1. Reset then idle: reset=1 for 2 cycles, then 0 with in_valid=0 -> count=0, out_valid=0, out_pc=0, out_instr=0, pc_en=1.
2. In-order streaming: push PCs 0x3000, 0x3004, 0x3008 with instrs 0x24010001/2/3 and out_ready=0, then out_ready=1 -> out_pc sequence 0x3000, 0x3004, 0x3008; each pair appears 1 cycle after its push.
3. Fill to full (DEPTH=4): push 5 times with out_ready=0 -> count=4, pc_en=0 after the 4th push, the 5th pair is not stored. One pop then gives count=3 and pc_en=1 on the following cycle.
4. Simultaneous push/pop at count=2 for 10 cycles -> count stays 2, pointers wrap past 3 to 0, output order is preserved across the wrap.
5. Flush while full with in_valid=1 and out_ready=1 -> pc_en=1 in the flush cycle, next cycle count=0, out_valid=0, and the pair offered during flush never appears at the outputs.
6. reset asserted together with push and flush at count=3 -> next cycle count=0, out_valid=0, pc_en=1; the first push after reset appears at the outputs unmodified.
